// File: rtl/fifo_sync_buffer_if.sv
// Producer/consumer bundle for fifo_sync_buffer: write port, read strobe, read data and status.
// No latency of its own; it only carries the signals between the two sides.
// Optional error flags (o_ovf/o_udf) exist only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_sync_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              i_wen;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ren_ctrl;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rvalid;
  logic              o_empty;
  logic              o_full;
  logic              o_afull;
  logic [ADDR_W:0]   o_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              o_ovf;
  logic              o_udf;
`endif

`ifdef FIFO_ERR_FLAGS_EN
  modport master (
    output i_wen, i_wdata, i_ren_ctrl,
    input  o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count, o_ovf, o_udf
  );
  modport slave (
    input  i_wen, i_wdata, i_ren_ctrl,
    output o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count, o_ovf, o_udf
  );
`else
  modport master (
    output i_wen, i_wdata, i_ren_ctrl,
    input  o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count
  );
  modport slave (
    input  i_wen, i_wdata, i_ren_ctrl,
    output o_rdata, o_rvalid, o_empty, o_full, o_afull, o_count
  );
`endif
endinterface

// File: rtl/fifo_sync_buffer.sv
// Single-clock FIFO storage stage fed by fifo_read_ctrl; flags and read data are registered.
// Latency: 1 cycle from an accepted read strobe to o_rvalid/o_rdata.
// Backpressure: writes dropped while full, strobes dropped while empty; FIFO_ERR_FLAGS_EN adds sticky o_ovf/o_udf.
module fifo_sync_buffer #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AFULL_TH = 14
) (
  input  logic          i_clk,
  input  logic          i_rest,
  fifo_sync_buffer_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AFULL_C   = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  // storage is deliberately left out of reset; the pointers define what is valid
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              empty_q;
  logic              full_q;
  logic              afull_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              wr_acc;
  logic              rd_acc;

  // Accept qualifiers use the registered flags only. The read strobe lags the
  // empty flag by a cycle upstream, so it must be re-checked here.
  always_comb begin
    wr_acc = bus.i_wen      & ~full_q;
    rd_acc = bus.i_ren_ctrl & ~empty_q;
  end

  // Next occupancy: simultaneous accepted read and write cancel out.
  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + CNT_ONE;
      2'b01:   count_nxt = count_q - CNT_ONE;
      default: count_nxt = count_q;
    endcase
  end

  // Memory write port; a concurrent read of the same slot sees the old word.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_rest) begin
      mem[wr_ptr_q] <= bus.i_wdata;
    end
  end

  // Pointer advance; ADDR_W-bit pointers wrap naturally at the depth.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Occupancy and status flags, all derived from the next count so they are
  // exact in the cycle following the update.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == DEPTH_C);
      afull_q <= (count_nxt >= AFULL_C);
    end
  end

  // Registered read port: o_rdata holds between accepted reads, o_rvalid pulses.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem[rd_ptr_q];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags: any write attempt while full / strobe while empty.
  always_ff @(posedge i_clk) begin
    if (i_rest) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.i_wen      & full_q);
      udf_q <= udf_q | (bus.i_ren_ctrl & empty_q);
    end
  end

  assign bus.o_ovf = ovf_q;
  assign bus.o_udf = udf_q;
`endif

  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_empty  = empty_q;
  assign bus.o_full   = full_q;
  assign bus.o_afull  = afull_q;
  assign bus.o_count  = count_q;

  // Occupancy can never exceed the depth, and empty/full are mutually exclusive.
  a_count_bound: assert property (@(posedge i_clk) disable iff (i_rest)
    count_q <= DEPTH_C);
  a_flag_excl: assert property (@(posedge i_clk) disable iff (i_rest)
    !(empty_q && full_q));

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// Directed self-checking bench for fifo_sync_buffer (default depth 16, AFULL_TH 14).
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
// Error-flag checks are compiled in only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_sync_buffer;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  fifo_sync_buffer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  fifo_sync_buffer #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14)) dut (
    .i_clk  (clk),
    .i_rest (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_wen      = 1'b0;
    bus.i_ren_ctrl = 1'b0;
  endtask

  // write n words base, base+1, ... on consecutive cycles
  task automatic push(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.i_wen   = 1'b1;
      bus.i_wdata = base + 8'(i);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.i_wdata = 8'h00;
    step();
    step();
    rst = 1'b0;
    tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got=%b exp=1", bus.o_empty); end
    tests_run++; if (bus.o_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got=%b exp=0", bus.o_full); end
    tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got=%0d exp=0", bus.o_count); end
    tests_run++; if (bus.o_rvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid got=%b exp=0", bus.o_rvalid); end
    tests_run++; if (bus.o_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=00", bus.o_rdata); end
    tests_run++; if (bus.o_afull !== 1'b0) begin tests_failed++; $display("FAIL reset_afull got=%b exp=0", bus.o_afull); end
`ifdef FIFO_ERR_FLAGS_EN
    tests_run++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin tests_failed++; $display("FAIL reset_errflags got=%b%b exp=00", bus.o_ovf, bus.o_udf); end
`endif
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      bus.i_wen   = 1'b1;
      bus.i_wdata = 8'(i);
      step();
      tests_run++; if (bus.o_count !== 5'(i + 1)) begin tests_failed++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.o_count, i + 1); end
      tests_run++; if (bus.o_afull !== ((i + 1) >= 14)) begin tests_failed++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, bus.o_afull, (i + 1) >= 14); end
      tests_run++; if (bus.o_full !== ((i + 1) == 16)) begin tests_failed++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, bus.o_full, (i + 1) == 16); end
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.i_ren_ctrl = 1'b1;
      step();
      tests_run++; if (bus.o_rvalid !== 1'b1) begin tests_failed++; $display("FAIL drain_rvalid[%0d] got=%b exp=1", i, bus.o_rvalid); end
      tests_run++; if (bus.o_rdata !== 8'(i)) begin tests_failed++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, bus.o_rdata, 8'(i)); end
      tests_run++; if (bus.o_count !== 5'(15 - i)) begin tests_failed++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.o_count, 15 - i); end
    end
    idle();
    step();
    tests_run++; if (bus.o_rvalid !== 1'b0) begin tests_failed++; $display("FAIL drain_rvalid_end got=%b exp=0", bus.o_rvalid); end
    tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty got=%b exp=1", bus.o_empty); end
    tests_run++; if (bus.o_rdata !== 8'h0F) begin tests_failed++; $display("FAIL drain_rdata_hold got=%h exp=0f", bus.o_rdata); end
  endtask

  task automatic test_wrap();
    push(10, 8'hA0);
    for (int i = 0; i < 10; i++) begin
      bus.i_ren_ctrl = 1'b1;
      step();
      tests_run++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'hA0 + 8'(i)) begin tests_failed++; $display("FAIL wrap_a_rd[%0d] got=%b/%h exp=1/%h", i, bus.o_rvalid, bus.o_rdata, 8'hA0 + 8'(i)); end
    end
    idle();
    push(12, 8'hB0);
    tests_run++; if (bus.o_count !== 5'd12) begin tests_failed++; $display("FAIL wrap_count_mid got=%0d exp=12", bus.o_count); end
    for (int i = 0; i < 12; i++) begin
      bus.i_ren_ctrl = 1'b1;
      step();
      tests_run++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'hB0 + 8'(i)) begin tests_failed++; $display("FAIL wrap_b_rd[%0d] got=%b/%h exp=1/%h", i, bus.o_rvalid, bus.o_rdata, 8'hB0 + 8'(i)); end
    end
    idle();
    tests_run++; if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL wrap_end got=%0d/%b exp=0/1", bus.o_count, bus.o_empty); end
  endtask

  task automatic test_simultaneous();
    push(16, 8'hC0);
    // full: write 0xEE rejected, head 0xC0 read out
    bus.i_wen = 1'b1; bus.i_wdata = 8'hEE; bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_count !== 5'd15) begin tests_failed++; $display("FAIL simfull_count got=%0d exp=15", bus.o_count); end
    tests_run++; if (bus.o_full !== 1'b0) begin tests_failed++; $display("FAIL simfull_full got=%b exp=0", bus.o_full); end
    tests_run++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'hC0) begin tests_failed++; $display("FAIL simfull_head got=%b/%h exp=1/c0", bus.o_rvalid, bus.o_rdata); end
`ifdef FIFO_ERR_FLAGS_EN
    tests_run++; if (bus.o_ovf !== 1'b1) begin tests_failed++; $display("FAIL simfull_ovf got=%b exp=1", bus.o_ovf); end
`endif
    // remaining words must be C1..CF with no trace of the rejected 0xEE
    for (int i = 1; i < 16; i++) begin
      bus.i_ren_ctrl = 1'b1;
      step();
      tests_run++; if (bus.o_rdata !== 8'hC0 + 8'(i)) begin tests_failed++; $display("FAIL simfull_rest[%0d] got=%h exp=%h", i, bus.o_rdata, 8'hC0 + 8'(i)); end
    end
    idle();
    step();
    tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL simfull_drained got=%b exp=1", bus.o_empty); end
    // empty: read rejected, write 0x5A accepted
    bus.i_wen = 1'b1; bus.i_wdata = 8'h5A; bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_count !== 5'd1) begin tests_failed++; $display("FAIL simempty_count got=%0d exp=1", bus.o_count); end
    tests_run++; if (bus.o_rvalid !== 1'b0) begin tests_failed++; $display("FAIL simempty_rvalid got=%b exp=0", bus.o_rvalid); end
    tests_run++; if (bus.o_empty !== 1'b0) begin tests_failed++; $display("FAIL simempty_empty got=%b exp=0", bus.o_empty); end
    // mid: both accepted, count stays 1, 0x5A out, 0x77 stored
    bus.i_wen = 1'b1; bus.i_wdata = 8'h77; bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_count !== 5'd1 || bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'h5A) begin tests_failed++; $display("FAIL simmid got=%0d/%b/%h exp=1/1/5a", bus.o_count, bus.o_rvalid, bus.o_rdata); end
    bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_rdata !== 8'h77 || bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL simmid_tail got=%h/%b exp=77/1", bus.o_rdata, bus.o_empty); end
  endtask

  // fifo_read_ctrl registers (i_ren & ~i_empty); with i_ren held high its strobe
  // stays up one cycle after the last word leaves, which must be rejected.
  task automatic test_ren_lag();
    int rv_cnt;
    rst = 1'b1; step(); rst = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    tests_run++; if (bus.o_udf !== 1'b0) begin tests_failed++; $display("FAIL lag_udf_pre got=%b exp=0", bus.o_udf); end
`endif
    push(1, 8'h3C);
    rv_cnt = 0;
    // ctrl saw empty=0 -> strobe; it still sees empty=0 at that edge -> strobe again
    bus.i_ren_ctrl = 1'b1;
    step();
    if (bus.o_rvalid === 1'b1) rv_cnt++;
    tests_run++; if (bus.o_rdata !== 8'h3C) begin tests_failed++; $display("FAIL lag_rdata got=%h exp=3c", bus.o_rdata); end
    step();
    if (bus.o_rvalid === 1'b1) rv_cnt++;
    // ctrl now sees empty=1 and drops its strobe
    idle();
    step();
    if (bus.o_rvalid === 1'b1) rv_cnt++;
    tests_run++; if (rv_cnt !== 1) begin tests_failed++; $display("FAIL lag_rvalid_count got=%0d exp=1", rv_cnt); end
    tests_run++; if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL lag_state got=%0d/%b exp=0/1", bus.o_count, bus.o_empty); end
`ifdef FIFO_ERR_FLAGS_EN
    tests_run++; if (bus.o_udf !== 1'b1) begin tests_failed++; $display("FAIL lag_udf got=%b exp=1", bus.o_udf); end
`endif
  endtask

  task automatic test_reset_midstream();
    // strobe while empty to make the underflow flag non-zero where present
    bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    push(7, 8'h40);
    tests_run++; if (bus.o_count !== 5'd7) begin tests_failed++; $display("FAIL midrst_pre_count got=%0d exp=7", bus.o_count); end
    bus.i_ren_ctrl = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    tests_run++; if (bus.o_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_rvalid got=%b exp=0", bus.o_rvalid); end
    tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL midrst_count got=%0d exp=0", bus.o_count); end
    tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL midrst_empty got=%b exp=1", bus.o_empty); end
`ifdef FIFO_ERR_FLAGS_EN
    tests_run++; if (bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0) begin tests_failed++; $display("FAIL midrst_errflags got=%b%b exp=00", bus.o_ovf, bus.o_udf); end
`endif
    step();
    tests_run++; if (bus.o_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midrst_rvalid_late got=%b exp=0", bus.o_rvalid); end
    // FIFO is usable right after reset
    push(1, 8'h99);
    bus.i_ren_ctrl = 1'b1;
    step();
    idle();
    tests_run++; if (bus.o_rvalid !== 1'b1 || bus.o_rdata !== 8'h99) begin tests_failed++; $display("FAIL midrst_after got=%b/%h exp=1/99", bus.o_rvalid, bus.o_rdata); end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus.i_wen      = 1'b0;
    bus.i_ren_ctrl = 1'b0;
    bus.i_wdata    = 8'h00;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_ren_lag();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
